// File: rtl/j202_wb_ctrl_regs_pkg.sv
// Shared constants for the j202 control/status register bank: register offsets,
// reset-sequencer state encoding and the byte-lane write merge.
package j202_ctrl_regs_pkg;

  localparam int unsigned WIN_BYTES = 64;
  localparam int unsigned WIN_AW    = $clog2(WIN_BYTES);

  localparam logic [WIN_AW-1:0] OFF_CTRL     = 6'h00;
  localparam logic [WIN_AW-1:0] OFF_STATUS   = 6'h04;
  localparam logic [WIN_AW-1:0] OFF_IRQ_STAT = 6'h08;
  localparam logic [WIN_AW-1:0] OFF_IRQ_EN   = 6'h0C;
  localparam logic [WIN_AW-1:0] OFF_SCRATCH0 = 6'h10;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_COUNT = 2'd1,
    ST_RUN   = 2'd2
  } rst_state_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/j202_wb_ctrl_regs_if.sv
// Wishbone slave-side bundle between the Caravel WB port and the j202 register bank.
interface j202_wb_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/j202_wb_ctrl_regs_rst_seq.sv
// j202 core reset sequencer: HOLD until run is requested, then keep the core in
// reset for RST_HOLD cycles before releasing it.
module j202_rst_seq
  import j202_ctrl_regs_pkg::*;
#(
  parameter int unsigned RST_HOLD = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_req,
  output logic core_rst_n
);

  localparam logic [7:0] CNT_LAST = 8'(RST_HOLD - 1);

  rst_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       core_rst_n_q, core_rst_n_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!run_req) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          state_d = ST_COUNT;
          cnt_d   = '0;
        end
        ST_COUNT: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_HOLD;
      endcase
    end
    // Output follows the next state so release lands on the same edge RUN is entered.
    core_rst_n_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HOLD;
      cnt_q        <= '0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

  assign core_rst_n = core_rst_n_q;

endmodule

// File: rtl/j202_wb_ctrl_regs.sv
// Wishbone control/status register bank for the j202 user area.
// Optional interrupt block (IRQ_STAT/IRQ_EN/irq_o) enabled by J202_CTRL_IRQ_EN.
module j202_wb_ctrl_regs
  import j202_ctrl_regs_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned NUM_SCRATCH = 4,
  parameter int unsigned STATUS_W    = 8,
  parameter int unsigned IRQ_W       = 4,
  parameter int unsigned RST_HOLD    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  j202_wb_if.slave            wb,
  input  logic [STATUS_W-1:0] status_i,
  input  logic [IRQ_W-1:0]    irq_src_i,
  output logic                core_rst_n_o,
  output logic [30:0]         ctrl_o,
  output logic                irq_o
);

  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic [31:0]       ctrl_q, ctrl_d;
  logic [STATUS_W-1:0] status_meta_q, status_meta_d;
  logic [STATUS_W-1:0] status_sync_q, status_sync_d;
  logic [WIN_AW-1:0] off;
  logic              hit, access, wr;
  logic [31:0]       rdata;
  logic [NUM_SCRATCH-1:0][31:0] scratch_rd;

  assign off = wb.wbs_adr_i[WIN_AW-1:0];
  assign hit = wb.wbs_cyc_i & wb.wbs_stb_i &
               (wb.wbs_adr_i[31:WIN_AW] == BASE_ADDR[31:WIN_AW]);
  // One access per ack: the cycle after an ack is always idle, even if stb stays high.
  assign access = hit & ~ack_q;
  assign wr     = access & wb.wbs_we_i;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SCRATCH; gi++) begin : g_scr
      localparam logic [WIN_AW-1:0] OFF_K = WIN_AW'(OFF_SCRATCH0 + 4 * gi);
      logic [31:0] scr_q, scr_d;

      always_comb begin
        scr_d = scr_q;
        if (wr && off == OFF_K) scr_d = byte_merge(scr_q, wb.wbs_dat_i, wb.wbs_sel_i);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) scr_q <= '0;
        else        scr_q <= scr_d;
      end

      assign scratch_rd[gi] = scr_q;
    end
  endgenerate

`ifdef J202_CTRL_IRQ_EN
  logic [IRQ_W-1:0] irq_prev_q, irq_prev_d;
  logic [IRQ_W-1:0] irq_stat_q, irq_stat_d;
  logic [IRQ_W-1:0] irq_en_q, irq_en_d;
  logic             irq_q, irq_d;
  logic [31:0]      w1c_word, en_word;

  always_comb begin
    w1c_word   = byte_merge(32'h0, wb.wbs_dat_i, wb.wbs_sel_i);
    en_word    = byte_merge(32'(irq_en_q), wb.wbs_dat_i, wb.wbs_sel_i);
    irq_prev_d = irq_src_i;
    irq_stat_d = irq_stat_q;
    if (wr && off == OFF_IRQ_STAT) irq_stat_d = irq_stat_q & ~w1c_word[IRQ_W-1:0];
    // New edges are ORed in after the clear so a coincident edge survives the W1C.
    irq_stat_d = irq_stat_d | (irq_src_i & ~irq_prev_q);
    irq_en_d   = irq_en_q;
    if (wr && off == OFF_IRQ_EN) irq_en_d = en_word[IRQ_W-1:0];
    irq_d      = |(irq_stat_q & irq_en_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev_q <= '0;
      irq_stat_q <= '0;
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_prev_q <= irq_prev_d;
      irq_stat_q <= irq_stat_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  logic unused_irq_src;
  assign unused_irq_src = ^irq_src_i;
  assign irq_o          = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL:     rdata = ctrl_q;
      OFF_STATUS:   rdata = 32'(status_sync_q);
`ifdef J202_CTRL_IRQ_EN
      OFF_IRQ_STAT: rdata = 32'(irq_stat_q);
      OFF_IRQ_EN:   rdata = 32'(irq_en_q);
`endif
      default: begin
        for (int k = 0; k < NUM_SCRATCH; k++) begin
          if (off == WIN_AW'(OFF_SCRATCH0 + 4 * k)) rdata = scratch_rd[k];
        end
      end
    endcase
  end

  always_comb begin
    ack_d         = access;
    dat_d         = access ? rdata : dat_q;
    ctrl_d        = ctrl_q;
    if (wr && off == OFF_CTRL) ctrl_d = byte_merge(ctrl_q, wb.wbs_dat_i, wb.wbs_sel_i);
    status_meta_d = status_i;
    status_sync_d = status_meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q         <= 1'b0;
      dat_q         <= '0;
      ctrl_q        <= '0;
      status_meta_q <= '0;
      status_sync_q <= '0;
    end else begin
      ack_q         <= ack_d;
      dat_q         <= dat_d;
      ctrl_q        <= ctrl_d;
      status_meta_q <= status_meta_d;
      status_sync_q <= status_sync_d;
    end
  end

  j202_rst_seq #(.RST_HOLD(RST_HOLD)) u_rst_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_req    (ctrl_q[0]),
    .core_rst_n (core_rst_n_o)
  );

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign ctrl_o       = ctrl_q[31:1];

endmodule
